// File: rtl/vec_cache_wr_tag_drain_if.sv
// ---------------------------------------------------------------------------
// vec_cache_wr_tag_drain_if
//  Bundles the three buses that meet at the write-tag drain:
//    - write-tag buffer : wr_tag_buf_vld/index/tag/way in, buf_clean_en out
//    - lookup pipeline  : lkp_req_vld/lkp_index in, lkp_req_rdy/lkp_hazard out
//    - tag RAM port     : tag_ram_en/wr/addr/wdata/wmask out
//  slave  : the drain itself
//  master : the environment (buffer + pipeline + RAM) driving the drain
// ---------------------------------------------------------------------------
interface vec_cache_wr_tag_drain_if #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 20,
    parameter int WAY_NUM = 8,
    parameter int WAY_W   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
);
    logic               wr_tag_buf_vld;
    logic [INDEX_W-1:0] wr_tag_buf_index;
    logic [TAG_W-1:0]   wr_tag_buf_tag;
    logic [WAY_W-1:0]   wr_tag_buf_way;
    logic               buf_clean_en;

    logic               lkp_req_vld;
    logic [INDEX_W-1:0] lkp_index;
    logic               lkp_req_rdy;
    logic               lkp_hazard;

    logic               tag_ram_en;
    logic               tag_ram_wr;
    logic [INDEX_W-1:0] tag_ram_addr;
    logic [TAG_W:0]     tag_ram_wdata;
    logic [WAY_NUM-1:0] tag_ram_wmask;

    modport slave (
        input  wr_tag_buf_vld, wr_tag_buf_index, wr_tag_buf_tag, wr_tag_buf_way,
        input  lkp_req_vld, lkp_index,
        output buf_clean_en, lkp_req_rdy, lkp_hazard,
        output tag_ram_en, tag_ram_wr, tag_ram_addr, tag_ram_wdata, tag_ram_wmask
    );

    modport master (
        output wr_tag_buf_vld, wr_tag_buf_index, wr_tag_buf_tag, wr_tag_buf_way,
        output lkp_req_vld, lkp_index,
        input  buf_clean_en, lkp_req_rdy, lkp_hazard,
        input  tag_ram_en, tag_ram_wr, tag_ram_addr, tag_ram_wdata, tag_ram_wmask
    );
endinterface

// File: rtl/vec_cache_wr_tag_drain.sv
// ---------------------------------------------------------------------------
// vec_cache_wr_tag_drain
//  Consumer side of the write-tag buffer. Captures the buffered {index,tag,way}
//  on the first valid cycle, writes it into the single-port tag RAM while
//  letting pipeline lookups win for at most MAX_DEFER consecutive cycles, then
//  pulses buf_clean_en for one cycle. Lookups that hit the still-unwritten
//  index while the write is pending are flagged with lkp_hazard.
//  Ports:
//    clk   - clock
//    rst_n - asynchronous active-low reset
//    bus   - slave modport of vec_cache_wr_tag_drain_if (buffer, lookup, RAM)
// ---------------------------------------------------------------------------
module vec_cache_wr_tag_drain #(
    parameter int INDEX_W   = 8,
    parameter int TAG_W     = 20,
    parameter int WAY_NUM   = 8,
    parameter int MAX_DEFER = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vec_cache_wr_tag_drain_if.slave       bus
);
    localparam int         WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam logic [3:0] MAX_D = 4'(MAX_DEFER);

    typedef enum logic [1:0] {IDLE, PEND, CLEAN} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_defer_cnt, w_defer_nxt;
    logic [INDEX_W-1:0] r_cap_index;
    logic [TAG_W-1:0]   r_cap_tag;
    logic [WAY_W-1:0]   r_cap_way;
    logic               w_capture;

    logic               w_rdy, w_hazard, w_clean;
    logic               w_en, w_wr;
    logic [INDEX_W-1:0] w_addr;
    logic [TAG_W:0]     w_wdata;
    logic [WAY_NUM-1:0] w_wmask;

    // Write wins once the pipeline is quiet or it has been deferred MAX_DEFER
    // times in a row, so the write can never starve.
    logic w_do_write;
    assign w_do_write = (r_state == PEND) &&
                        (!bus.lkp_req_vld || (r_defer_cnt == MAX_D));

    always_comb begin
        w_state_nxt = r_state;
        w_defer_nxt = r_defer_cnt;
        w_capture   = 1'b0;
        // Default RAM use is the lookup read; only the PEND write overrides it.
        w_rdy       = 1'b1;
        w_en        = bus.lkp_req_vld;
        w_wr        = 1'b0;
        w_addr      = bus.lkp_index;
        w_wdata     = '0;
        w_wmask     = '0;
        w_clean     = 1'b0;
        w_hazard    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.wr_tag_buf_vld) begin
                    // Buffer payload is only guaranteed on this first vld cycle.
                    w_capture   = 1'b1;
                    w_defer_nxt = '0;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (w_do_write) begin
                    w_rdy       = 1'b0;
                    w_en        = 1'b1;
                    w_wr        = 1'b1;
                    w_addr      = r_cap_index;
                    w_wdata     = {1'b1, r_cap_tag};
                    w_wmask     = WAY_NUM'(1) << r_cap_way;
                    w_state_nxt = CLEAN;
                end else begin
                    // Here a lookup is present and defer_cnt < MAX_DEFER, so
                    // the increment cannot pass the limit.
                    w_hazard    = (bus.lkp_index == r_cap_index);
                    w_defer_nxt = r_defer_cnt + 4'd1;
                end
            end
            CLEAN: begin
                // vld is ignored here; a still-high vld re-captures from IDLE.
                w_clean     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_defer_cnt <= '0;
            r_cap_index <= '0;
            r_cap_tag   <= '0;
            r_cap_way   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_defer_cnt <= w_defer_nxt;
            if (w_capture) begin
                r_cap_index <= bus.wr_tag_buf_index;
                r_cap_tag   <= bus.wr_tag_buf_tag;
                r_cap_way   <= bus.wr_tag_buf_way;
            end
        end
    end

    assign bus.lkp_req_rdy   = w_rdy;
    assign bus.lkp_hazard    = w_hazard;
    assign bus.buf_clean_en  = w_clean;
    assign bus.tag_ram_en    = w_en;
    assign bus.tag_ram_wr    = w_wr;
    assign bus.tag_ram_addr  = w_addr;
    assign bus.tag_ram_wdata = w_wdata;
    assign bus.tag_ram_wmask = w_wmask;
endmodule

// File: tb/tb_vec_cache_wr_tag_drain.sv
// ---------------------------------------------------------------------------
// tb_vec_cache_wr_tag_drain
//  Directed bench: idle write, deferral with hazards, back-to-back entries and
//  reset mid-PEND, with hand-computed expected values, plus cycle monitors for
//  RAM access exclusivity and single-cycle clean pulses.
// ---------------------------------------------------------------------------
module tb_vec_cache_wr_tag_drain;
    localparam int INDEX_W = 8, TAG_W = 20, WAY_NUM = 8, MAX_DEFER = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0, n_bad = 0;
    int   n_clean = 0, n_wr = 0;
    logic prev_clean = 1'b0;

    vec_cache_wr_tag_drain_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAY_NUM(WAY_NUM)) ifc ();

    vec_cache_wr_tag_drain #(
        .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAY_NUM(WAY_NUM), .MAX_DEFER(MAX_DEFER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full RAM port plus handshake outputs in one go.
    task automatic chk_out(input string tag, input logic rdy, input logic en, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] wmask, input logic clean, input logic haz);
        chk({tag, ".rdy"},   32'(ifc.lkp_req_rdy),   32'(rdy));
        chk({tag, ".en"},    32'(ifc.tag_ram_en),    32'(en));
        chk({tag, ".wr"},    32'(ifc.tag_ram_wr),    32'(wr));
        if (en) chk({tag, ".addr"}, 32'(ifc.tag_ram_addr), addr);
        chk({tag, ".wdata"}, 32'(ifc.tag_ram_wdata), wdata);
        chk({tag, ".wmask"}, 32'(ifc.tag_ram_wmask), wmask);
        chk({tag, ".clean"}, 32'(ifc.buf_clean_en),  32'(clean));
        chk({tag, ".haz"},   32'(ifc.lkp_hazard),    32'(haz));
    endtask

    // Per-cycle invariants: a write never coexists with a grant or a disabled
    // RAM, and the clean pulse is never wider than one cycle.
    always @(negedge clk) begin
        n_cmp++;
        assert (!(ifc.tag_ram_wr && (ifc.lkp_req_rdy || !ifc.tag_ram_en))) else begin
            n_bad++;
            $error("FAIL access_excl: observed wr=%0b rdy=%0b en=%0b expected single access",
                   ifc.tag_ram_wr, ifc.lkp_req_rdy, ifc.tag_ram_en);
        end
        n_cmp++;
        assert (!(prev_clean && ifc.buf_clean_en)) else begin
            n_bad++;
            $error("FAIL clean_width: observed 2-cycle pulse expected 1");
        end
        prev_clean = ifc.buf_clean_en;
        if (ifc.buf_clean_en === 1'b1) n_clean++;
        if (ifc.tag_ram_en === 1'b1 && ifc.tag_ram_wr === 1'b1) n_wr++;
    end

    initial begin
        int clean0;
        rst_n = 1'b0;
        ifc.wr_tag_buf_vld = 0; ifc.wr_tag_buf_index = '0; ifc.wr_tag_buf_tag = '0;
        ifc.wr_tag_buf_way = '0; ifc.lkp_req_vld = 0; ifc.lkp_index = '0;
        #2;
        chk_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // ---- idle write ----
        ifc.wr_tag_buf_vld = 1; ifc.wr_tag_buf_index = 8'h12;
        ifc.wr_tag_buf_tag = 20'hABCDE; ifc.wr_tag_buf_way = 3'd3;
        #1 chk_out("idle.T", 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        // Payload is no longer valid; the captured copy must be used.
        ifc.wr_tag_buf_index = 8'hFF; ifc.wr_tag_buf_tag = 20'h00000; ifc.wr_tag_buf_way = 3'd0;
        #1 chk_out("idle.T1", 0, 1, 1, 32'h12, 32'h1ABCDE, 32'h08, 0, 0);
        step();
        ifc.wr_tag_buf_vld = 0;
        #1 chk_out("idle.T2", 1, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 chk_out("idle.T3", 1, 0, 0, 0, 0, 0, 0, 0);

        // ---- deferral with hazards ----
        ifc.wr_tag_buf_vld = 1; ifc.wr_tag_buf_index = 8'h12;
        ifc.wr_tag_buf_tag = 20'h55555; ifc.wr_tag_buf_way = 3'd0;
        ifc.lkp_req_vld = 1; ifc.lkp_index = 8'h12;
        #1 chk_out("defer.T", 1, 1, 0, 32'h12, 0, 0, 0, 0);
        for (int k = 1; k <= MAX_DEFER; k++) begin
            step();
            ifc.lkp_index = (k == 2) ? 8'h13 : 8'h12;
            #1 chk_out($sformatf("defer.T%0d", k), 1, 1, 0, 32'(ifc.lkp_index), 0, 0, 0,
                       (k != 2));
        end
        step();
        ifc.lkp_index = 8'h12;
        #1 chk_out("defer.T5", 0, 1, 1, 32'h12, 32'h155555, 32'h01, 0, 0);
        step();
        ifc.wr_tag_buf_vld = 0;
        #1 chk_out("defer.T6", 1, 1, 0, 32'h12, 0, 0, 1, 0);
        step();
        ifc.lkp_req_vld = 0;
        #1 chk_out("defer.T7", 1, 0, 0, 0, 0, 0, 0, 0);

        // ---- back-to-back entries ----
        clean0 = n_clean;
        ifc.wr_tag_buf_vld = 1; ifc.wr_tag_buf_index = 8'h20;
        ifc.wr_tag_buf_tag = 20'h11111; ifc.wr_tag_buf_way = 3'd7;
        step();
        #1 chk_out("b2b.W1", 0, 1, 1, 32'h20, 32'h111111, 32'h80, 0, 0);
        step();
        ifc.wr_tag_buf_index = 8'h40; ifc.wr_tag_buf_tag = 20'h22222; ifc.wr_tag_buf_way = 3'd5;
        #1 chk_out("b2b.C1", 1, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 chk_out("b2b.cap", 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1 chk_out("b2b.W2", 0, 1, 1, 32'h40, 32'h122222, 32'h20, 0, 0);
        step();
        ifc.wr_tag_buf_vld = 0;
        #1 chk_out("b2b.C2", 1, 0, 0, 0, 0, 0, 1, 0);
        step(); step();
        chk("b2b.clean_pulses", 32'(n_clean - clean0), 32'd2);

        // ---- reset mid-PEND ----
        clean0 = n_clean;
        ifc.wr_tag_buf_vld = 1; ifc.wr_tag_buf_index = 8'h33;
        ifc.wr_tag_buf_tag = 20'h0F0F0; ifc.wr_tag_buf_way = 3'd1;
        ifc.lkp_req_vld = 1; ifc.lkp_index = 8'h33;
        step();
        #1 chk_out("rst.pend", 1, 1, 0, 32'h33, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1 chk_out("rst.async", 1, 1, 0, 32'h33, 0, 0, 0, 0);
        ifc.wr_tag_buf_vld = 0; ifc.lkp_req_vld = 0;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            #1 chk_out($sformatf("rst.after%0d", k), 1, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("rst.no_clean", 32'(n_clean - clean0), 32'd0);

        // Four entries written in total, each with exactly one clean pulse.
        chk("total_writes", 32'(n_wr), 32'd4);
        chk("total_cleans", 32'(n_clean), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
